// File: rtl/inv_add_round_key.sv
// Final AddRoundKey stage of an AES-128 decryption pipeline: holds the expanded
// key schedule and XORs the selected round key into a one-deep output register.
module inv_add_round_key (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         key_clear,
    input  logic         key_wr_en,
    input  logic [31:0]  key_wr_data,
    output logic         keys_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_skip_mix,
    output logic         out_err
);

    localparam logic [5:0] NUM_WORDS = 6'd44;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    logic [31:0]  key_word [44];
    logic [5:0]   wcnt;
    logic [5:0]   wcnt_next;
    logic         key_we;
    logic         round_ok;
    logic [5:0]   base;
    logic [127:0] round_key;
    logic [127:0] next_state;
    logic         transfer;

    // A clear in the same cycle as a write discards the word.
    assign key_we = key_wr_en && !key_clear && (wcnt != NUM_WORDS);

    always_comb begin
        wcnt_next = wcnt;
        if (key_clear)
            wcnt_next = '0;
        else if (key_we)
            wcnt_next = wcnt + 6'd1;
    end

    // NOTE: the key store has no reset; validity is tracked solely by wcnt, so
    // the words can map onto plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (key_we)
            key_word[wcnt] <= key_wr_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wcnt       <= '0;
            keys_ready <= 1'b0;
        end else begin
            wcnt       <= wcnt_next;
            keys_ready <= (wcnt_next == NUM_WORDS);
        end
    end

    // Out-of-range rounds point at word 0 so the lookup never leaves the array.
    assign round_ok  = (in_round <= LAST_ROUND);
    assign base      = round_ok ? {in_round, 2'b00} : 6'd0;
    assign round_key = {key_word[base], key_word[base + 6'd1],
                        key_word[base + 6'd2], key_word[base + 6'd3]};
    assign next_state = round_ok ? (in_state ^ round_key) : in_state;

    assign in_ready = keys_ready && (!out_valid || out_ready);
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid    <= 1'b0;
            out_state    <= '0;
            out_round    <= '0;
            out_skip_mix <= 1'b0;
            out_err      <= 1'b0;
        end else if (transfer) begin
            out_valid    <= 1'b1;
            out_state    <= next_state;
            out_round    <= in_round;
            out_skip_mix <= (in_round == 4'd0) || (in_round >= LAST_ROUND);
            out_err      <= !round_ok;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/inv_add_round_key.md
INV_ADD_ROUND_KEY -- requirements
Module: inv_add_round_key

Interface
REQ-001 Parameters: none; widths fixed for AES-128, with 11 round keys held as 44 words of 32 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 key_clear  input  1  synchronous pulse that invalidates the stored key schedule.
REQ-005 key_wr_en  input  1  write strobe for one key-schedule word.
REQ-006 key_wr_data  input  32  expanded-key word w[i], written in order i = 0..43.
REQ-007 keys_ready  output  1  high when all 44 words are loaded.
REQ-008 in_valid  input  1  upstream state word is valid.
REQ-009 in_ready  output  1  block accepts the input this cycle.
REQ-010 in_state  input  128  AES state; column 0 in [127:96], column 3 in [31:0].
REQ-011 in_round  input  4  round index 0..10 selecting round key.
REQ-012 out_valid  output  1  output register holds a result.
REQ-013 out_ready  input  1  downstream (inverse MixColumns / next stage) accepts the result.
REQ-014 out_state  output  128  in_state XOR round key.
REQ-015 out_round  output  4  registered copy of in_round.
REQ-016 out_skip_mix  output  1  high when out_round is 0 or 10, so the downstream stage bypasses inverse MixColumns.
REQ-017 out_err  output  1  high when out_round > 10.

Function
REQ-018 Key store: 44 x 32-bit registers plus a 6-bit write counter wcnt (0..44).
REQ-019 When key_wr_en=1 and wcnt<44, the block SHALL store key_wr_data into word[wcnt] and increment wcnt.
REQ-020 When key_wr_en=1 and wcnt=44, the write SHALL be ignored, with no wrap-around.
REQ-021 keys_ready SHALL equal (wcnt==44), registered.
REQ-022 key_clear=1 SHALL set wcnt to 0 next cycle.
REQ-023 If key_clear and key_wr_en are both high, clear SHALL win and the word SHALL be discarded.
REQ-024 Stored word contents need not be cleared on key_clear or reset.
REQ-025 Round key r SHALL be {word[4r], word[4r+1], word[4r+2], word[4r+3]}, with word[4r] in [127:96].
REQ-026 in_ready SHALL equal keys_ready AND (NOT out_valid OR out_ready), combinationally.
REQ-027 A transfer occurs when in_valid AND in_ready.
REQ-028 Latency is 1 cycle: on a transfer, the output registers load and out_valid is set on the next edge.
REQ-029 For in_round <= 10: out_state = in_state XOR roundkey(in_round), out_err = 0.
REQ-030 For in_round > 10: out_state = in_state unmodified, out_err = 1, out_skip_mix = 1.
REQ-031 out_valid clears on an edge where out_ready=1 and there is no new transfer.
REQ-032 Back-to-back transfers with out_ready held high SHALL sustain 1 result per cycle.
REQ-033 While out_valid=1 and out_ready=0, out_state, out_round, out_skip_mix and out_err SHALL hold stable.
REQ-034 key_clear while out_valid=1 SHALL NOT disturb the held output; in_ready falls the cycle after the clear.
REQ-035 Key writes during streaming are legal only when keys_ready=0; no hazard checking is required.

Reset
REQ-036 On n_rst=0, asynchronously: wcnt=0, keys_ready=0, out_valid=0, out_state=0, out_round=0, out_skip_mix=0, out_err=0.
REQ-037 in_ready SHALL be 0 during reset and until keys_ready=1.
REQ-038 Reset asserted mid-transfer SHALL drop any pending output; there is no recovery of in-flight data.

Verification
REQ-039 Load the FIPS-197 expanded key for 000102030405060708090a0b0c0d0e0f (44 words); send in_state=69c4e0d86a7b0430d8cdb78070b4c55a, in_round=10 -> one cycle later out_state=7ad5fda789ef4e272bca100b3d9ff59f, out_skip_mix=1, out_err=0.
REQ-040 Before 44 words are loaded, in_valid=1 -> in_ready=0 and out_valid stays 0; the 44th write -> keys_ready=1 the next cycle; a 45th write leaves all words unchanged.
REQ-041 Hold out_ready=0 for 5 cycles with in_valid=1 -> first result held stable, in_ready=0; release -> 1 result per cycle, none lost or duplicated.
REQ-042 in_round=11, in_state=all-ones -> out_state=all-ones, out_err=1; in_round=5 -> out_skip_mix=0.
REQ-043 key_clear together with key_wr_en, then n_rst pulse while out_valid=1 -> wcnt=0, keys_ready=0, out_valid=0 immediately on reset.
